// File: rtl/sha.sv
// Shared SHA definitions: algorithm modes, block/length geometry
// and the padding byte used by the message front end.
package sha;

  typedef enum logic [2:0] {
    M_SHA1,
    M_SHA224,
    M_SHA256,
    M_SHA384,
    M_SHA512,
    M_SHA512_224,
    M_SHA512_256
  } mode_t;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  function automatic logic small_blk(input mode_t m);
    return m inside {M_SHA1, M_SHA224, M_SHA256};
  endfunction

  function automatic logic [5:0] blk_words(input mode_t m);
    return small_blk(m) ? 6'd16 : 6'd32;
  endfunction

  function automatic logic [5:0] len_words(input mode_t m);
    return small_blk(m) ? 6'd2 : 6'd4;
  endfunction

endpackage

// File: rtl/sha_pad_word.sv
// Final-word shaping: keeps the valid leading bytes, zeroes the
// rest and drops the 0x80 marker into the first free byte.
module sha_pad_word
  import sha::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_bytes,
  output logic [31:0] o_word,
  output logic        o_pend
);

  always_comb begin
    o_word = i_data;
    o_pend = 1'b0;
    case (i_bytes)
      3'd0: o_word = {PAD_BYTE, 24'h0};
      3'd1: o_word = {i_data[31:24], PAD_BYTE, 16'h0};
      3'd2: o_word = {i_data[31:16], PAD_BYTE, 8'h0};
      3'd3: o_word = {i_data[31:8], PAD_BYTE};
      default: o_pend = 1'b1;
    endcase
  end

endmodule

// File: rtl/sha_msg_sequencer.sv
// Message front end for sha_engine: word intake, FIPS padding,
// block issue and digest handoff.
module sha_msg_sequencer
  import sha::*;
#(
  parameter int LEN_W = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  input  logic [2:0]    in_bytes,
  input  mode_t         in_mode,
  output logic          eng_valid,
  input  logic          eng_ready,
  output logic          eng_new_msg,
  output mode_t         eng_mode,
  output logic [1023:0] eng_msg,
  input  logic [511:0]  eng_hash,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic [511:0]  dig_data,
  output logic          dig_err,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_LEN,
    S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t r_state, w_state_n;
  state_t r_ret, w_ret_n;
  mode_t  r_mode;
  mode_t  w_mode;
  logic   r_first, r_pad80, r_seen_low, r_err;
  logic [5:0] r_idx;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0] r_buf [32];
  logic [511:0] r_dig;

  logic [5:0] w_bw, w_lw;
  logic [4:0] w_hi, w_lo;
  logic [31:0] w_pword;
  logic w_pend, w_hs, w_sha1, w_big;
  logic [LEN_W-1:0] w_base, w_add;
  logic [63:0] w_len;

  sha_pad_word u_pad (
    .i_data  (in_data),
    .i_bytes (in_bytes),
    .o_word  (w_pword),
    .o_pend  (w_pend)
  );

  // Mode comes straight from the port on the opening word.
  assign w_mode = (r_state == S_IDLE) ? in_mode : r_mode;
  assign w_bw   = blk_words(w_mode);
  assign w_lw   = len_words(w_mode);
  assign w_hi   = 5'(w_bw - 6'd1);
  assign w_lo   = 5'(w_bw - 6'd2);
  assign w_sha1 = (w_mode == M_SHA1);
  assign w_big  = (blk_words(r_mode) == 6'd32);
  assign w_hs   = in_valid & in_ready;
  assign w_base = (r_state == S_IDLE) ? '0 : r_cnt;
  assign w_add  = in_last ? LEN_W'(in_bytes) : LEN_W'(4);
  assign w_len  = 64'({r_cnt, 3'b000});

  assign in_ready    = (r_state == S_IDLE) || (r_state == S_FILL);
  assign eng_valid   = (r_state == S_ISSUE) && eng_ready;
  assign eng_new_msg = eng_valid & r_first;
  assign eng_mode    = r_mode;
  assign dig_valid   = (r_state == S_DONE);
  assign dig_data    = r_dig;
  assign dig_err     = dig_valid & r_err;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    eng_msg = '0;
    for (int i = 0; i < 32; i++) begin
      if (w_big)
        eng_msg[1023-32*i -: 32] = r_buf[i];
      else if (i < 16)
        eng_msg[511-32*i -: 32] = r_buf[i];
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ret_n   = r_ret;
    case (r_state)
      S_IDLE, S_FILL: begin
        if (w_hs) begin
          if (w_sha1)
            w_state_n = in_last ? S_DONE : S_FILL;
          else if (in_last)
            w_state_n = S_PAD;
          else if (r_idx + 6'd1 == w_bw) begin
            w_state_n = S_ISSUE;
            w_ret_n   = S_FILL;
          end else
            w_state_n = S_FILL;
        end
      end
      S_PAD: begin
        if (r_idx == w_bw) begin
          w_state_n = S_ISSUE;
          w_ret_n   = S_PAD;
        end else if (!r_pad80 && r_idx == w_bw - w_lw)
          w_state_n = S_LEN;
      end
      S_LEN: begin
        w_state_n = S_ISSUE;
        w_ret_n   = S_DONE;
      end
      S_ISSUE: if (eng_ready) w_state_n = S_WAIT;
      S_WAIT: if (eng_ready && r_seen_low) w_state_n = r_ret;
      S_DONE: if (dig_ready) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_ret   <= S_IDLE;
    end else begin
      r_state <= w_state_n;
      r_ret   <= w_ret_n;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode     <= M_SHA1;
      r_first    <= 1'b0;
      r_pad80    <= 1'b0;
      r_seen_low <= 1'b0;
      r_err      <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_dig      <= '0;
      for (int i = 0; i < 32; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_hs) begin
            if (r_state == S_IDLE) begin
              r_mode  <= in_mode;
              r_first <= 1'b1;
              r_err   <= w_sha1;
              r_dig   <= '0;
            end
            r_cnt <= w_base + w_add;
            // sha1 words are swallowed; nothing reaches the buffer
            if (!w_sha1) begin
              r_buf[r_idx[4:0]] <= in_last ? w_pword : in_data;
              r_idx   <= r_idx + 6'd1;
              r_pad80 <= in_last & w_pend;
            end
          end
        end
        S_PAD: begin
          if (r_idx != w_bw) begin
            if (r_pad80) begin
              r_buf[r_idx[4:0]] <= {PAD_BYTE, 24'h0};
              r_idx   <= r_idx + 6'd1;
              r_pad80 <= 1'b0;
            end else if (r_idx != w_bw - w_lw)
              r_idx <= r_idx + 6'd1;
          end
        end
        S_LEN: begin
          r_buf[w_lo] <= w_len[63:32];
          r_buf[w_hi] <= w_len[31:0];
          r_idx       <= w_bw;
        end
        S_ISSUE: begin
          if (eng_ready) begin
            r_first    <= 1'b0;
            r_seen_low <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!eng_ready)
            r_seen_low <= 1'b1;
          else if (r_seen_low) begin
            r_idx <= '0;
            for (int i = 0; i < 32; i++) r_buf[i] <= '0;
            if (r_ret == S_DONE) r_dig <= eng_hash;
          end
        end
        S_DONE: begin
          if (dig_ready) begin
            r_dig <= '0;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_sequencer.sv
// Directed bench for sha_msg_sequencer with a behavioural engine
// that records every issued block and returns a preset digest.
module tb_sha_msg_sequencer;
  import sha::*;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic [2:0]    in_bytes;
  mode_t         in_mode;
  logic          eng_valid;
  logic          eng_ready = 1'b1;
  logic          eng_new_msg;
  mode_t         eng_mode;
  logic [1023:0] eng_msg;
  logic [511:0]  eng_hash = '0;
  logic          dig_valid;
  logic          dig_ready;
  logic [511:0]  dig_data;
  logic          dig_err;
  logic          busy;

  sha_msg_sequencer #(.LEN_W(64)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .in_mode     (in_mode),
    .eng_valid   (eng_valid),
    .eng_ready   (eng_ready),
    .eng_new_msg (eng_new_msg),
    .eng_mode    (eng_mode),
    .eng_msg     (eng_msg),
    .eng_hash    (eng_hash),
    .dig_valid   (dig_valid),
    .dig_ready   (dig_ready),
    .dig_data    (dig_data),
    .dig_err     (dig_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  logic [1023:0] blk_msg [64];
  logic          blk_new [64];
  mode_t         blk_mode [64];
  int            nblk = 0;
  int            bcnt = 0;
  logic [511:0]  g_hash = '0;

  // engine: busy for 3 cycles per block, junk hash while busy
  always @(posedge clk) begin
    if (!rstn) begin
      eng_ready <= 1'b1;
      bcnt      <= 0;
    end else if (eng_valid) begin
      blk_msg[nblk]  <= eng_msg;
      blk_new[nblk]  <= eng_new_msg;
      blk_mode[nblk] <= eng_mode;
      nblk      <= nblk + 1;
      eng_ready <= 1'b0;
      eng_hash  <= {16{32'hdeadbeef}};
      bcnt      <= 3;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        eng_ready <= 1'b1;
        eng_hash  <= g_hash;
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1023:0] pw(input logic [1023:0] e,
    input bit big, input int i, input logic [31:0] w);
    logic [1023:0] r;
    r = e;
    if (big) r[1023-32*i -: 32] = w;
    else r[511-32*i -: 32] = w;
    return r;
  endfunction

  task automatic put(input logic [31:0] d, input logic last,
    input logic [2:0] nb, input mode_t m, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_mode  = m;
    t = 0;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_dig(input string tag, input logic [511:0] exp,
    input logic eerr, input int hold);
    int t;
    logic ok;
    logic [511:0] d0;
    t = 0;
    while (!dig_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".dv"}, 512'(dig_valid), 512'(1));
    ok = 1'b1;
    d0 = dig_data;
    repeat (hold) begin
      @(negedge clk);
      if (!dig_valid || dig_data !== d0) ok = 1'b0;
    end
    if (hold > 0) check({tag, ".hold"}, 512'(ok), 512'(1));
    check({tag, ".dig"}, dig_data, exp);
    check({tag, ".err"}, 512'(dig_err), 512'(eerr));
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    check({tag, ".idle"}, 512'({dig_valid, busy}), 512'(0));
  endtask

  task automatic chk_blk(input string tag, input int k,
    input logic [1023:0] e, input logic nm, input mode_t m);
    logic [1023:0] b;
    b = blk_msg[k];
    check({tag, ".hi"}, b[1023:512], e[1023:512]);
    check({tag, ".lo"}, b[511:0], e[511:0]);
    check({tag, ".new"}, 512'(blk_new[k]), 512'(nm));
    check({tag, ".mode"}, 512'(blk_mode[k]), 512'(m));
  endtask

  logic [31:0] w56 [14] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071
  };

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [1023:0] e;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_bytes = '0;
    in_mode = M_SHA256;
    dig_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ctl", 512'({in_ready, busy, eng_valid, eng_new_msg,
          dig_valid, dig_err}), 512'(6'b100000));
    check("rst.mode", 512'(eng_mode), 512'(0));
    check("rst.msg", eng_msg[1023:512] | eng_msg[511:0], '0);
    check("rst.dig", dig_data, '0);
    rstn = 1'b1;
    @(negedge clk);

    // SHA-256 empty message
    g_hash = 512'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    base = nblk;
    put(32'h12345678, 1'b1, 3'd0, M_SHA256, 0);
    get_dig("t1", g_hash, 1'b0, 0);
    check("t1.nblk", 512'(nblk - base), 512'(1));
    e = pw('0, 0, 0, 32'h80000000);
    chk_blk("t1.b0", base, e, 1'b1, M_SHA256);

    // SHA-256 "abc", junk in the unused byte
    g_hash = 512'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    base = nblk;
    put(32'h616263ff, 1'b1, 3'd3, M_SHA256, 1);
    get_dig("t2", g_hash, 1'b0, 0);
    e = pw('0, 0, 0, 32'h61626380);
    e = pw(e, 0, 15, 32'h18);
    chk_blk("t2.b0", base, e, 1'b1, M_SHA256);

    // SHA-256 "ab"
    g_hash = 512'h1234;
    base = nblk;
    put(32'h6162eeee, 1'b1, 3'd2, M_SHA256, 0);
    get_dig("t2b", g_hash, 1'b0, 0);
    e = pw('0, 0, 0, 32'h61628000);
    e = pw(e, 0, 15, 32'h10);
    chk_blk("t2b.b0", base, e, 1'b1, M_SHA256);

    // SHA-512 "abc"
    g_hash = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    base = nblk;
    put(32'h616263aa, 1'b1, 3'd3, M_SHA512, 0);
    get_dig("t3", g_hash, 1'b0, 0);
    check("t3.nblk", 512'(nblk - base), 512'(1));
    e = pw('0, 1, 0, 32'h61626380);
    e = pw(e, 1, 31, 32'h18);
    chk_blk("t3.b0", base, e, 1'b1, M_SHA512);

    // SHA-256 56 bytes: 0x80 spills, length lands in block 2
    g_hash = 512'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    base = nblk;
    for (int i = 0; i < 14; i++)
      put(w56[i], i == 13, 3'd4, M_SHA256, 0);
    get_dig("t4", g_hash, 1'b0, 0);
    check("t4.nblk", 512'(nblk - base), 512'(2));
    e = '0;
    for (int i = 0; i < 14; i++) e = pw(e, 0, i, w56[i]);
    e = pw(e, 0, 14, 32'h80000000);
    chk_blk("t4.b0", base, e, 1'b1, M_SHA256);
    e = pw('0, 0, 15, 32'h1c0);
    chk_blk("t4.b1", base + 1, e, 1'b0, M_SHA256);

    // SHA-256 65 bytes: full block issued mid-stream
    g_hash = 512'h5555aaaa;
    base = nblk;
    for (int i = 0; i < 16; i++)
      put(32'(i + 1), 1'b0, 3'd4, M_SHA256, 0);
    put(32'haabbccdd, 1'b1, 3'd1, M_SHA256, 0);
    get_dig("t5", g_hash, 1'b0, 0);
    check("t5.nblk", 512'(nblk - base), 512'(2));
    e = '0;
    for (int i = 0; i < 16; i++) e = pw(e, 0, i, 32'(i + 1));
    chk_blk("t5.b0", base, e, 1'b1, M_SHA256);
    e = pw('0, 0, 0, 32'haa800000);
    e = pw(e, 0, 15, 32'h208);
    chk_blk("t5.b1", base + 1, e, 1'b0, M_SHA256);

    // SHA-224 "abc" with an input gap and a slow digest consumer
    g_hash = 512'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
    base = nblk;
    put(32'h61626300, 1'b1, 3'd3, M_SHA224, int'($urandom_range(2, 6)));
    get_dig("t6", g_hash, 1'b0, 10);
    check("t6.nblk", 512'(nblk - base), 512'(1));
    e = pw('0, 0, 0, 32'h61626380);
    e = pw(e, 0, 15, 32'h18);
    chk_blk("t6.b0", base, e, 1'b1, M_SHA224);

    // sha1 is refused: error digest, no engine traffic
    g_hash = 512'hffff;
    base = nblk;
    put(32'h11111111, 1'b0, 3'd4, M_SHA1, 0);
    put(32'h22222222, 1'b1, 3'd2, M_SHA1, 0);
    get_dig("t7", '0, 1'b1, 0);
    check("t7.nblk", 512'(nblk - base), 512'(0));

    // abort mid-block, then SHA-384 "abc"
    for (int i = 0; i < 3; i++)
      put(32'hc0de0000 + 32'(i), 1'b0, 3'd4, M_SHA256, 0);
    check("t8.busy", 512'(busy), 512'(1));
    rstn = 1'b0;
    @(negedge clk);
    check("t8.rst", 512'({in_ready, busy, dig_valid, eng_valid}),
          512'(4'b1000));
    check("t8.msg", eng_msg[1023:512] | eng_msg[511:0], '0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("t8.nodig", 512'({dig_valid, busy}), 512'(0));
    g_hash = 512'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7;
    base = nblk;
    put(32'h61626377, 1'b1, 3'd3, M_SHA384, 0);
    get_dig("t8", g_hash, 1'b0, 0);
    check("t8.nblk", 512'(nblk - base), 512'(1));
    e = pw('0, 1, 0, 32'h61626380);
    e = pw(e, 1, 31, 32'h18);
    chk_blk("t8.b0", base, e, 1'b1, M_SHA384);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/sha_msg_sequencer.md
Name: sha_msg_sequencer

Overview:
Front-end controller for sha_engine. It accepts a message as a stream of 32-bit big-endian words and applies FIPS 180-4 padding: the 0x80 byte, zero fill, and a 64-bit or 128-bit length field. It assembles 512- or 1024-bit blocks, issues them to the engine one at a time with correct new_msg marking, and presents the final digest through a valid/ready handshake. It sits between the host/DMA word stream and sha_engine and is the only driver of the engine's bus.

Parameters:
LEN_W, 64, width of the message byte counter; for 384/512-family modes the upper 64 bits of the 128-bit length field are always zero.

Ports:
clk  in  1  single clock
rstn  in  1  reset, asynchronous, active-low
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
in_data  in  32  message word, first byte in [31:24]
in_last  in  1  final word of message
in_bytes  in  3  valid bytes in last word, 1..4; 0 only for an empty message (data ignored)
in_mode  in  sha::mode_t  algorithm, sampled on the first word of a message
eng_valid  out  1  block request to engine
eng_ready  in  1  engine ready
eng_new_msg  out  1  first block of the message
eng_mode  out  sha::mode_t  latched mode
eng_msg  out  1024  block; 256-family: first word at [511:480], [1023:512]=0; 512-family: first word at [1023:992]
eng_hash  in  512  engine digest, right-aligned
dig_valid  out  1  digest available
dig_ready  in  1  digest consumed
dig_data  out  512  digest, right-aligned, unused upper bits zero
dig_err  out  1  with dig_valid: unsupported mode (sha1)
busy  out  1  message in progress

Behaviour:
- Reset values: all outputs 0 except in_ready=1. State S_IDLE, counters 0, block buffer 0.
- Block size BW = 16 words (sha224/256) or 32 words (384/512/512_224/512_256). Length words LW = 2 or 4.
- S_IDLE: in_ready=1. A handshake latches mode, sets first_blk=1, writes the word at index 0 and goes to S_FILL. If in_last is also set, the padding path below applies immediately. A sha1 mode word is consumed without being stored; sha1 goes straight to S_DONE with dig_err=1 and dig_data=0 once the last word has been taken.
- S_FILL: in_ready=1. Each handshake writes word[idx], idx++, and byte_cnt += 4 (or in_bytes on last). When idx reaches BW, in_ready drops the next cycle and the FSM goes to S_ISSUE with ret=S_FILL.
- Last word with in_bytes 1..3: bytes beyond in_bytes are zero, and 0x80 is placed in the first invalid byte. With in_bytes=4: the next word is 0x80000000. With in_bytes=0: word[idx]=0x80000000. After this go to S_PAD. If the block fills before 0x80 is placed, set pad80_pend and insert it as word 0 of the next block.
- S_PAD: writes zero words (or pending 0x80) until idx == BW-LW. If idx > BW-LW at entry, zero-fill to BW, issue, then continue padding in a fresh block.
- S_LEN: writes the length in bits (byte_cnt<<3) big-endian across LW words, zero-extended, then S_ISSUE with ret=S_DONE.
- S_ISSUE: waits for eng_ready=1, then asserts eng_valid for exactly 1 cycle with eng_new_msg=first_blk. Clear first_blk and go to S_WAIT.
- S_WAIT: waits for eng_ready to be seen 0 and then 1 (seen_low flag). Then clear the buffer and idx, and go to ret.
- S_DONE: capture dig_data = eng_hash and set dig_valid=1, held until dig_ready. Then go to S_IDLE.
- in_ready=0 outside S_IDLE/S_FILL. eng_msg is stable from S_ISSUE until eng_ready returns.
- busy=1 whenever state != S_IDLE.
- Byte counter wraps modulo 2^LEN_W; no error is flagged.
- rstn low mid-message aborts at once with no digest. The engine is reset by the same rstn.

Decomposition:
- sha package: mode_t (existing); a block-words function (16/32) and a length-words function (2/4) keyed by mode_t; the 0x80 pad-byte constant.
- One sub-module, sha_pad_word: combinational last-word masking and 0x80 insertion from (in_data, in_bytes).
- The FSM, counters and block buffer stay in sha_msg_sequencer.

Test Plan:
- SHA-256, empty message (in_bytes=0, in_last) -> one block with new_msg=1; dig_data[255:0]=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- SHA-256 "abc" (0x61626300, in_bytes=3) -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- SHA-512 "abc" -> one 1024-bit block with length word 0x18; dig_data=ddaf35a1...a54ca49f.
- SHA-256 56-byte "abcdbcdecdefdefg...nopq" -> two blocks (second has new_msg=0); dig 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- SHA-224 "abc" with random in_valid gaps and dig_ready held low 10 cycles -> 23097d22...7da7; dig_valid held stable; exactly one eng_valid pulse.
- rstn asserted mid-block, then SHA-384 "abc" -> no stale digest; result cb00753f...a7cc2358baeca134c825a7.
